dmem_port_ctrl: RTL and testbench
=================================

// Module: dmem_port_ctrl
// PURPOSE
// Data-memory port controller in the MEM stage, directly downstream of the performance-counter unit.
// Consumes its filtered read/write strobes and drives the single-port data cache/memory.
// Absorbs stores into a small posted write buffer and generates pipeline_continue for the whole pipeline.
// counter_unit consumes pipeline_continue for its stall, cache-miss and data-hold logic.
// PARAMETERS
// WB_DEPTH  4  write-buffer entries; power of 2, range 2..16
// PORTS
// clk                input   1   pipeline clock; all state updates on posedge
// rst                input   1   asynchronous, active-high reset
// read               input   1   load request from counter_unit read_out; held stable while stalled
// write              input   1   store request from counter_unit write_out; held stable while stalled
// mem_address        input   32  byte address of the request
// wdata              input   32  store data
// wmask              input   4   store byte enables
// rdata              output  32  load data; valid only in the cycle pipeline_continue=1 completes a load
// pipeline_continue  output  1   1 = current MEM request retires this cycle and the pipeline advances
// mem_read           output  1   memory read strobe; held until mem_resp
// mem_write          output  1   memory write strobe; held until mem_resp
// mem_addr           output  32  memory address
// mem_wdata          output  32  memory write data
// mem_byte_enable    output  4   memory byte enables
// mem_resp           input   1   one-cycle completion of the outstanding memory operation
// mem_rdata          input   32  read data; valid with mem_resp
// BEHAVIOUR
// - Reset (async): FIFO count=0, pointers=0, FSM=IDLE.
//   mem_read=mem_write=0, mem_addr/mem_wdata/mem_byte_enable=0, rdata=0.
//   pipeline_continue=1 unless a read is presented.
//   In-flight memory operations and buffered stores are discarded.
// - Memory handshake: at most one operation outstanding.
//   Strobes and addr/data/be stay registered and constant from issue until the mem_resp cycle.
//   Strobes deassert in the cycle after mem_resp.
// - FSM states: IDLE, WB_WRITE (draining the FIFO head), RD_WAIT (load outstanding).
// - Store path: if write=1 and count<WB_DEPTH (registered count), the entry {addr, data, mask} is enqueued at posedge.
//   pipeline_continue=1 in that cycle (zero-stall store).
// - Store when full: pipeline_continue=0 until count<WB_DEPTH.
//   A slot freed by mem_resp becomes usable the next cycle; no same-cycle bypass.
// - Drain: IDLE with count>0 -> WB_WRITE, issuing the head entry.
//   On mem_resp, dequeue; go to IDLE (a further entry issues the next cycle).
// - Load path (drain-before-read, no store forwarding): read=1 gives pipeline_continue=0.
//   First the FIFO drains completely, including any write already in flight.
//   Then IDLE -> RD_WAIT issues mem_read with the word address.
//   On mem_resp in RD_WAIT: rdata=mem_rdata combinationally, pipeline_continue=1, FSM -> IDLE.
// - Priority in IDLE: while read=1 and count>0, continue draining writes. Issue the load only when count=0.
// - Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
// - Pointers wrap modulo WB_DEPTH. count is $clog2(WB_DEPTH)+1 bits. full: count==WB_DEPTH. empty: count==0.
// - No request (read=write=0): pipeline_continue=1 and background draining continues.
// - read and write are never both 1 (upstream guarantee); an assertion checks this.
// - Counter addresses 0x50-0x53 never reach this block, because counter_unit masks those strobes.
// STRUCTURE
// - dmem_pkg holds:
//   - the state enum (IDLE/WB_WRITE/RD_WAIT);
//   - wb_entry_t {logic [31:0] addr; logic [31:0] data; logic [3:0] mask;};
//   - WB_DEPTH_DEFAULT.
// - Sub-module wb_fifo #(WB_DEPTH): synchronous FIFO of wb_entry_t with async reset.
//   Ports: enq, deq, head, count, full, empty.
// - Top level: FSM, memory-port output registers, pipeline_continue/rdata logic.
// TESTING
// 1) Reset, then 3 stores 0x100/0x104/0x108 back-to-back, mem_resp 2 cycles after each issue.
//    -> pipeline_continue=1 all 3 cycles; memory sees 3 writes in order, data/mask intact.
// 2) 5 stores with WB_DEPTH=4 and memory stalled (mem_resp=0).
//    -> 5th store holds pipeline_continue=0 until the cycle after the first mem_resp; then it enqueues.
// 3) Store 0x200=0xDEADBEEF then load 0x200.
//    -> load issued only after the write's mem_resp; rdata=0xDEADBEEF when pipeline_continue=1.
// 4) Load with empty buffer, mem_resp after 3 cycles, mem_rdata=0x12345678.
//    -> pipeline_continue=0 for 3 cycles, then 1 for 1 cycle with rdata=0x12345678.
// 5) Assert rst mid-WB_WRITE with 2 entries queued.
//    -> mem_write=0 immediately (async), count=0; no further writes after release.
// 6) Fill and drain 20 entries continuously.
//    -> pointer wrap correct, memory write order equals enqueue order, count never exceeds 4.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types for the data-memory port controller
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB_WRITE,
    RD_WAIT
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wb_entry_t;

  localparam int WB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/dmem_port_ctrl_wb_fifo.sv
// rtl/dmem_port_ctrl_wb_fifo.sv - posted store buffer, power-of-2 ring
module wb_fifo
  import dmem_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq,
  input  logic                      deq,
  input  wb_entry_t                 data,
  output wb_entry_t                 head,
  output logic [$clog2(WB_DEPTH):0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = $clog2(WB_DEPTH);

  wb_entry_t         entries [WB_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_enq;
  logic              do_deq;

  assign full   = (count == (PW+1)'(WB_DEPTH));
  assign empty  = (count == '0);
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;
  assign head   = entries[rd_ptr];

  // Storage is left out of the reset domain; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_enq) entries[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// rtl/dmem_port_ctrl.sv - MEM-stage port controller: posted stores, drain-before-read loads
module dmem_port_ctrl
  import dmem_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] mem_address,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        pipeline_continue,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(WB_DEPTH) + 1;

  state_t          state;
  wb_entry_t       head;
  wb_entry_t       new_entry;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            enq;
  logic            deq;
  logic            rd_done;

  assign new_entry = '{addr: mem_address, data: wdata, mask: wmask};
  assign enq       = write && !full;
  assign deq       = (state == WB_WRITE) && mem_resp;
  assign rd_done   = (state == RD_WAIT) && mem_resp;

  // Stores retire on acceptance; loads only when their own response returns.
  assign pipeline_continue = read ? rd_done : (write ? !full : 1'b1);
  assign rdata             = rd_done ? mem_rdata : '0;

  wb_fifo #(.WB_DEPTH(WB_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .enq   (enq),
    .deq   (deq),
    .data  (new_entry),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Buffered stores always go first so a load never overtakes them.
          if (!empty) begin
            state           <= WB_WRITE;
            mem_write       <= 1'b1;
            mem_addr        <= head.addr;
            mem_wdata       <= head.data;
            mem_byte_enable <= head.mask;
          end else if (read) begin
            state           <= RD_WAIT;
            mem_read        <= 1'b1;
            mem_addr        <= {mem_address[31:2], 2'b00};
            mem_byte_enable <= 4'hF;
          end
        end
        WB_WRITE: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_write <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem_resp) begin
            state    <= IDLE;
            mem_read <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(read && write));
  a_count_bound:  assert property (@(posedge clk) disable iff (rst) count <= CW'(WB_DEPTH));

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb/tb_dmem_port_ctrl.sv - directed vector bench for dmem_port_ctrl
module tb_dmem_port_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [31:0] mem_address, wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        pipeline_continue, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_port_ctrl #(.WB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .mem_address(mem_address),
    .wdata(wdata), .wmask(wmask), .rdata(rdata), .pipeline_continue(pipeline_continue),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: auto response lat cycles after issue, or on demand via fire.
  logic [31:0] mem_model [logic [31:0]];
  wb_entry_t   wlog [$];
  wb_entry_t   exp_log [$];
  int          lat = 2;
  bit          manual = 0;
  bit          fire = 0;
  int          age = 0;
  int          maxc = 0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  initial begin
    mem_resp  = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_resp = 1'b0; age = 0; fire = 0;
      end else if (mem_resp) begin
        mem_resp = 1'b0; age = 0;
      end else if (mem_read || mem_write) begin
        age++;
        if (manual ? fire : (age == lat + 1)) begin
          mem_resp  = 1'b1;
          fire      = 0;
          mem_rdata = rd_word(mem_addr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_resp && mem_write) begin
      logic [31:0] w;
      wlog.push_back('{addr: mem_addr, data: mem_wdata, mask: mem_byte_enable});
      w = rd_word(mem_addr);
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
      mem_model[mem_addr] = w;
    end
    if (int'(dut.u_fifo.count) > maxc) maxc = int'(dut.u_fifo.count);
  end

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wd;
    logic [3:0]  mask;
    logic        pc, mw, mr;
    bit          chk_rd;
    logic [31:0] rdv;
    bit          chk_a;
    logic [31:0] a;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] mask, input logic pc,
                             input logic mw, input logic mr, input bit chk_rd,
                             input logic [31:0] rdv, input bit chk_a, input logic [31:0] a);
    v = '{rd, wr, addr, wd, mask, pc, mw, mr, chk_rd, rdv, chk_a, a};
  endfunction

  task automatic check_log(input string tag);
    chk({tag, "_log_size"}, wlog.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < wlog.size(); i++) begin
      chk($sformatf("%s_log%0d_addr", tag, i), wlog[i].addr, exp_log[i].addr);
      chk($sformatf("%s_log%0d_data", tag, i), wlog[i].data, exp_log[i].data);
      chk($sformatf("%s_log%0d_mask", tag, i), wlog[i].mask, exp_log[i].mask);
    end
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((dut.u_fifo.count != 0 || mem_write || mem_read) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_drain_timeout"}, g < 500, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0;
    mem_address = '0; wdata = '0; wmask = '0;
    mem_model[32'h300] = 32'h12345678;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc_idle", pipeline_continue, 1'b1);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", mem_byte_enable, 4'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_count", dut.u_fifo.count, 0);
    read = 1'b1; #1;
    chk("rst_pc_read", pipeline_continue, 1'b0);
    read = 1'b0;
    @(negedge clk) rst = 1'b0;

    // Three posted stores, store-then-load, and a load with an empty buffer
    tbl.push_back(v(0,1,'h100,'h11111111,'hF, 1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,'h104,'h22222222,'h3, 1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,1,'h108,'h33333333,'hC, 1,1,0, 0,0, 1,'h100));
    tbl.push_back(v(0,0,0,0,0, 1,1,0, 0,0, 0,0));
    tbl.push_back(v(0,0,0,0,0, 1,1,0, 0,0, 0,0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,0,0,0,0, 1,1,0, 0,0, 1,'h104));
    tbl.push_back(v(0,0,0,0,0, 1,1,0, 0,0, 0,0));
    tbl.push_back(v(0,0,0,0,0, 1,1,0, 0,0, 0,0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0, 0,0, 0,0));
    tbl.push_back(v(0,0,0,0,0, 1,1,0, 0,0, 1,'h108));
    tbl.push_back(v(0,0,0,0,0, 1,1,0, 0,0, 0,0));
    tbl.push_back(v(0,0,0,0,0, 1,1,0, 0,0, 0,0));
    tbl.push_back(v(0,1,'h200,'hDEADBEEF,'hF, 1,0,0, 0,0, 0,0));
    tbl.push_back(v(1,0,'h200,0,0, 0,0,0, 0,0, 0,0));
    tbl.push_back(v(1,0,'h200,0,0, 0,1,0, 0,0, 1,'h200));
    tbl.push_back(v(1,0,'h200,0,0, 0,1,0, 0,0, 0,0));
    tbl.push_back(v(1,0,'h200,0,0, 0,1,0, 0,0, 0,0));
    tbl.push_back(v(1,0,'h200,0,0, 0,0,0, 0,0, 0,0));
    tbl.push_back(v(1,0,'h200,0,0, 0,0,1, 0,0, 1,'h200));
    tbl.push_back(v(1,0,'h200,0,0, 0,0,1, 0,0, 0,0));
    tbl.push_back(v(1,0,'h200,0,0, 1,0,1, 1,'hDEADBEEF, 0,0));
    tbl.push_back(v(1,0,'h302,0,0, 0,0,0, 0,0, 0,0));
    tbl.push_back(v(1,0,'h302,0,0, 0,0,1, 0,0, 1,'h300));
    tbl.push_back(v(1,0,'h302,0,0, 0,0,1, 0,0, 0,0));
    tbl.push_back(v(1,0,'h302,0,0, 1,0,1, 1,'h12345678, 0,0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0, 0,0, 0,0));

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk); #1;
      read = tbl[k].rd; write = tbl[k].wr;
      mem_address = tbl[k].addr; wdata = tbl[k].wd; wmask = tbl[k].mask;
      @(negedge clk);
      chk($sformatf("v%0d_pc", k), pipeline_continue, tbl[k].pc);
      chk($sformatf("v%0d_mem_write", k), mem_write, tbl[k].mw);
      chk($sformatf("v%0d_mem_read", k), mem_read, tbl[k].mr);
      if (tbl[k].chk_rd) chk($sformatf("v%0d_rdata", k), rdata, tbl[k].rdv);
      if (tbl[k].chk_a) chk($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].a);
    end
    exp_log.push_back('{addr: 32'h100, data: 32'h11111111, mask: 4'hF});
    exp_log.push_back('{addr: 32'h104, data: 32'h22222222, mask: 4'h3});
    exp_log.push_back('{addr: 32'h108, data: 32'h33333333, mask: 4'hC});
    exp_log.push_back('{addr: 32'h200, data: 32'hDEADBEEF, mask: 4'hF});
    check_log("vec");

    // Five stores into a stalled memory: fifth waits for the first response
    wlog.delete(); exp_log.delete(); manual = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      write = 1'b1; mem_address = 32'h400 + 4*i; wdata = 32'hA0000000 + i; wmask = 4'hF;
      exp_log.push_back('{addr: mem_address, data: wdata, mask: wmask});
      @(negedge clk);
      chk($sformatf("full_st%0d_pc", i), pipeline_continue, i < 4);
    end
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1; @(negedge clk);
      chk($sformatf("full_hold%0d_pc", j), pipeline_continue, 1'b0);
    end
    fire = 1;
    @(posedge clk); #1; @(negedge clk);
    chk("full_resp_cycle_resp", mem_resp, 1'b1);
    chk("full_resp_cycle_pc", pipeline_continue, 1'b0);
    @(posedge clk); #1; @(negedge clk);
    chk("full_after_resp_pc", pipeline_continue, 1'b1);
    manual = 0;
    @(posedge clk); #1; write = 1'b0;
    drain("full");
    check_log("full");

    // Async reset in the middle of a buffered write
    wlog.delete(); manual = 1;
    @(posedge clk); #1; write = 1'b1; mem_address = 32'h500; wdata = 32'h55555555; wmask = 4'hF;
    @(posedge clk); #1; mem_address = 32'h504; wdata = 32'h66666666;
    @(posedge clk); #1; write = 1'b0;
    @(negedge clk);
    chk("rstmid_pre_mem_write", mem_write, 1'b1);
    chk("rstmid_pre_count", dut.u_fifo.count, 2);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_mem_write", mem_write, 1'b0);
    chk("rstmid_count", dut.u_fifo.count, 0);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    @(negedge clk) rst = 1'b0;
    manual = 0;
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (mem_write) seen++;
      end
      chk("rstmid_writes_after", seen, 0);
      chk("rstmid_log_size", wlog.size(), 0);
    end

    // Continuous fill and drain of 20 entries through the 4-deep ring
    wlog.delete(); exp_log.delete(); maxc = 0;
    begin
      int i = 0;
      int g = 0;
      while (i < 20 && g < 2000) begin
        @(posedge clk); #1;
        write = 1'b1; mem_address = 32'h1000 + 4*i; wdata = 32'hC0DE0000 + i; wmask = 4'(i + 1);
        @(negedge clk);
        if (pipeline_continue) begin
          exp_log.push_back('{addr: mem_address, data: wdata, mask: wmask});
          i++;
        end
        g++;
      end
      chk("wrap_enq_done", i, 20);
    end
    @(posedge clk); #1; write = 1'b0;
    drain("wrap");
    check_log("wrap");
    chk("wrap_max_count", maxc, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
